mem_inerf: RTL and testbench

MEM_INERF -- requirements
Module: mem_inerf (companion model: sram_single_port)

---
 rtl/mem_inerf.sv | 148 ++++++++++++++
 tb/tb_mem_inerf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_inerf.sv
// ---------------------------------------------------------------------------
// mem_inerf: memory interface between an instruction unit and a single-port
// byte SRAM. A level-held store or load request is latched in IDLE, driven to
// the SRAM as a write/read strobe until the SRAM answers with mem_resp, and
// then acknowledged with mem_done. mem_done is held until the requester drops
// both store and load (four-phase handshake).
//
// Ports:
//   clk, reset_n       clock, synchronous active-low reset
//   store, load        level-held requests (store wins when both are high)
//   result[15:0]       store data
//   addr[13:0]         byte address
//   mem_resp           one-cycle completion pulse from the SRAM
//   datafrommem[7:0]   SRAM read data
//   datatomem[15:0]    latched store data to the SRAM
//   addrout[13:0]      latched address to the SRAM
//   write_req/read_req SRAM strobes
//   mem_done           operation complete
//   datatoinst[7:0]    last byte read
//
// sram_single_port: companion 16K x 8 SRAM model. A 16-bit write stores two
// bytes little-endian at addr and addr+1 (wrapping at 0x3FFF). Each access is
// answered by a single mem_resp pulse one cycle after the access; strobes are
// ignored while the response is pending or being issued.
// ---------------------------------------------------------------------------
module mem_inerf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        store,
    input  logic        load,
    input  logic [15:0] result,
    input  logic [13:0] addr,
    input  logic        mem_resp,
    input  logic [7:0]  datafrommem,
    output logic [15:0] datatomem,
    output logic [13:0] addrout,
    output logic        write_req,
    output logic        read_req,
    output logic        mem_done,
    output logic [7:0]  datatoinst
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            datatomem  <= '0;
            addrout    <= '0;
            write_req  <= 1'b0;
            read_req   <= 1'b0;
            mem_done   <= 1'b0;
            datatoinst <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Address and data are captured here so that requester
                    // changes during the access cannot disturb it.
                    if (store) begin
                        addrout   <= addr;
                        datatomem <= result;
                        write_req <= 1'b1;
                        state     <= WRITE;
                    end else if (load) begin
                        addrout  <= addr;
                        read_req <= 1'b1;
                        state    <= READ;
                    end
                end
                WRITE: begin
                    if (mem_resp) begin
                        write_req <= 1'b0;
                        mem_done  <= 1'b1;
                        state     <= DONE;
                    end
                end
                READ: begin
                    if (mem_resp) begin
                        read_req   <= 1'b0;
                        datatoinst <= datafrommem;
                        mem_done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // Stay here while any request is still held so a
                    // level-held request cannot retrigger.
                    if (!store && !load) begin
                        mem_done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

module sram_single_port (
    input  logic        reset_n,
    input  logic        clk,
    input  logic        re,
    input  logic        we,
    input  logic [13:0] addr,
    input  logic [15:0] datafrommif,
    output logic [7:0]  datatomif,
    output logic        mem_resp
);

    logic [7:0]  mem [0:16383];
    logic        pend;
    logic        idle;
    logic        do_wr;
    logic        do_rd;
    logic [13:0] addr_hi;

    // Busy from the access edge through the cycle mem_resp is high, so a
    // held strobe is accepted only once.
    assign idle    = !pend && !mem_resp;
    assign do_wr   = reset_n && idle && we;
    assign do_rd   = reset_n && idle && re && !we;
    assign addr_hi = addr + 14'd1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend      <= 1'b0;
            mem_resp  <= 1'b0;
            datatomif <= '0;
        end else begin
            mem_resp <= pend;
            pend     <= do_wr || do_rd;
            if (do_rd)
                datatomif <= mem[addr];
        end
    end

    // Array has no reset: contents survive reset_n.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[addr]    <= datafrommif[7:0];
            mem[addr_hi] <= datafrommif[15:8];
        end
    end

endmodule

// File: tb/tb_mem_inerf.sv
module tb_mem_inerf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        store, load;
    logic [15:0] result;
    logic [13:0] addr;
    logic        mem_resp;
    logic [7:0]  datafrommem;
    logic [15:0] datatomem;
    logic [13:0] addrout;
    logic        write_req, read_req, mem_done;
    logic [7:0]  datatoinst;

    int n_cmp = 0;
    int n_err = 0;
    int wr_bursts = 0;
    int rd_bursts = 0;
    int resp_pulses = 0;
    logic prev_wr = 1'b0, prev_rd = 1'b0;

    always #5 clk = ~clk;

    mem_inerf dut (
        .clk(clk), .reset_n(reset_n), .store(store), .load(load),
        .result(result), .addr(addr), .mem_resp(mem_resp),
        .datafrommem(datafrommem), .datatomem(datatomem), .addrout(addrout),
        .write_req(write_req), .read_req(read_req), .mem_done(mem_done),
        .datatoinst(datatoinst)
    );

    sram_single_port u_sram (
        .reset_n(reset_n), .clk(clk), .re(read_req), .we(write_req),
        .addr(addrout), .datafrommif(datatomem), .datatomif(datafrommem),
        .mem_resp(mem_resp)
    );

    always @(posedge clk) begin
        if (write_req && !prev_wr) wr_bursts++;
        if (read_req && !prev_rd) rd_bursts++;
        if (mem_resp) resp_pulses++;
        prev_wr = write_req;
        prev_rd = read_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Drives one request, scrambles addr/result after the request is sampled,
    // holds the request for 'hold' cycles, then releases it.
    // lat  = cycles from the sampling edge until mem_done is seen (-1 = never)
    // gaps = cycles where mem_done dropped after it had risen while held
    task automatic run_req(input logic st, input logic ld, input logic [13:0] a,
                           input logic [15:0] d, input int hold,
                           output int lat, output int gaps, output logic done_rel);
        @(posedge clk); #1;
        store = st; load = ld; addr = a; result = d;
        @(posedge clk); #1;
        addr = a ^ 14'h155; result = ~d;
        lat = -1; gaps = 0;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); #1;
            if (mem_done) begin
                if (lat < 0) lat = i;
            end else if (lat >= 0) begin
                gaps++;
            end
        end
        store = 1'b0; load = 1'b0;
        @(posedge clk); #1;
        done_rel = mem_done;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; store = 0; load = 0; addr = '0; result = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (write_req !== 1'b0) begin n_err++; $display("FAIL reset_write_req: got %b want 0", write_req); end
        n_cmp++; if (read_req !== 1'b0) begin n_err++; $display("FAIL reset_read_req: got %b want 0", read_req); end
        n_cmp++; if (mem_done !== 1'b0) begin n_err++; $display("FAIL reset_mem_done: got %b want 0", mem_done); end
        n_cmp++; if (datatomem !== 16'h0) begin n_err++; $display("FAIL reset_datatomem: got %h want 0", datatomem); end
        n_cmp++; if (addrout !== 14'h0) begin n_err++; $display("FAIL reset_addrout: got %h want 0", addrout); end
        n_cmp++; if (datatoinst !== 8'h0) begin n_err++; $display("FAIL reset_datatoinst: got %h want 0", datatoinst); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        int lat, gaps, w0, r0;
        logic rel;
        w0 = wr_bursts; r0 = rd_bursts;
        run_req(1'b1, 1'b0, 14'h000A, 16'h1234, 10, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL write_latency: got %0d want 3", lat); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL write_done_held: dropped %0d cycles want 0", gaps); end
        n_cmp++; if (rel !== 1'b0) begin n_err++; $display("FAIL write_done_release: got %b want 0", rel); end
        n_cmp++; if (wr_bursts - w0 !== 1) begin n_err++; $display("FAIL write_bursts: got %0d want 1", wr_bursts - w0); end
        n_cmp++; if (rd_bursts - r0 !== 0) begin n_err++; $display("FAIL write_no_read: got %0d want 0", rd_bursts - r0); end
        n_cmp++; if (u_sram.mem[14'h000A] !== 8'h34) begin n_err++; $display("FAIL write_mem_lo: got %h want 34", u_sram.mem[14'h000A]); end
        n_cmp++; if (u_sram.mem[14'h000B] !== 8'h12) begin n_err++; $display("FAIL write_mem_hi: got %h want 12", u_sram.mem[14'h000B]); end
        n_cmp++; if (addrout !== 14'h000A) begin n_err++; $display("FAIL write_addr_latched: got %h want 000a", addrout); end
    endtask

    task automatic test_read;
        int lat, gaps, w0, r0;
        logic rel;
        w0 = wr_bursts; r0 = rd_bursts;
        run_req(1'b0, 1'b1, 14'h000A, 16'h0000, 10, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL read_latency: got %0d want 3", lat); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL read_done_held: dropped %0d cycles want 0", gaps); end
        n_cmp++; if (rel !== 1'b0) begin n_err++; $display("FAIL read_done_release: got %b want 0", rel); end
        n_cmp++; if (datatoinst !== 8'h34) begin n_err++; $display("FAIL read_data: got %h want 34", datatoinst); end
        n_cmp++; if (rd_bursts - r0 !== 1) begin n_err++; $display("FAIL read_bursts: got %0d want 1", rd_bursts - r0); end
        n_cmp++; if (wr_bursts - w0 !== 0) begin n_err++; $display("FAIL read_no_write: got %0d want 0", wr_bursts - w0); end
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (datatoinst !== 8'h34) begin n_err++; $display("FAIL read_data_hold: got %h want 34", datatoinst); end
    endtask

    task automatic test_priority;
        int lat, gaps, w0, r0;
        logic rel;
        w0 = wr_bursts; r0 = rd_bursts;
        run_req(1'b1, 1'b1, 14'h0020, 16'h5678, 10, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL prio_latency: got %0d want 3", lat); end
        n_cmp++; if (wr_bursts - w0 !== 1) begin n_err++; $display("FAIL prio_write_bursts: got %0d want 1", wr_bursts - w0); end
        n_cmp++; if (rd_bursts - r0 !== 0) begin n_err++; $display("FAIL prio_no_read: got %0d want 0", rd_bursts - r0); end
        n_cmp++; if (u_sram.mem[14'h0020] !== 8'h78) begin n_err++; $display("FAIL prio_mem_lo: got %h want 78", u_sram.mem[14'h0020]); end
        n_cmp++; if (u_sram.mem[14'h0021] !== 8'h56) begin n_err++; $display("FAIL prio_mem_hi: got %h want 56", u_sram.mem[14'h0021]); end
        n_cmp++; if (datatoinst !== 8'h34) begin n_err++; $display("FAIL prio_datatoinst_kept: got %h want 34", datatoinst); end
    endtask

    task automatic test_wrap;
        int lat, gaps;
        logic rel;
        run_req(1'b1, 1'b0, 14'h3FFF, 16'hBEEF, 10, lat, gaps, rel);
        n_cmp++; if (u_sram.mem[14'h3FFF] !== 8'hEF) begin n_err++; $display("FAIL wrap_mem_3fff: got %h want ef", u_sram.mem[14'h3FFF]); end
        n_cmp++; if (u_sram.mem[14'h0000] !== 8'hBE) begin n_err++; $display("FAIL wrap_mem_0000: got %h want be", u_sram.mem[14'h0000]); end
        run_req(1'b0, 1'b1, 14'h0000, 16'h0000, 10, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL wrap_read_latency: got %0d want 3", lat); end
        n_cmp++; if (datatoinst !== 8'hBE) begin n_err++; $display("FAIL wrap_read_data: got %h want be", datatoinst); end
    endtask

    task automatic test_reset_midop;
        int lat, gaps, p0;
        logic rel;
        @(posedge clk); #1;
        store = 1'b1; addr = 14'h0100; result = 16'hA55A;
        @(posedge clk); #1;
        n_cmp++; if (write_req !== 1'b1) begin n_err++; $display("FAIL midop_write_started: got %b want 1", write_req); end
        reset_n = 1'b0; store = 1'b0;
        p0 = resp_pulses;
        @(posedge clk); #1;
        n_cmp++; if ({write_req, read_req, mem_done} !== 3'b000) begin n_err++; $display("FAIL midop_strobes: got %b want 000", {write_req, read_req, mem_done}); end
        n_cmp++; if (datatomem !== 16'h0 || addrout !== 14'h0 || datatoinst !== 8'h0) begin
            n_err++; $display("FAIL midop_data: got %h/%h/%h want 0/0/0", datatomem, addrout, datatoinst); end
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (resp_pulses - p0 !== 0) begin n_err++; $display("FAIL midop_abandoned: resp pulses %0d want 0", resp_pulses - p0); end
        run_req(1'b1, 1'b0, 14'h0200, 16'hC3D4, 10, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL midop_restart_latency: got %0d want 3", lat); end
        n_cmp++; if (u_sram.mem[14'h0200] !== 8'hD4 || u_sram.mem[14'h0201] !== 8'hC3) begin
            n_err++; $display("FAIL midop_restart_mem: got %h%h want c3d4", u_sram.mem[14'h0201], u_sram.mem[14'h0200]); end
    endtask

    task automatic test_held;
        int lat, gaps, w0, p0;
        logic rel;
        w0 = wr_bursts; p0 = resp_pulses;
        run_req(1'b1, 1'b0, 14'h0040, 16'h9ABC, 20, lat, gaps, rel);
        n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL held_latency: got %0d want 3", lat); end
        n_cmp++; if (gaps !== 0) begin n_err++; $display("FAIL held_done_continuous: dropped %0d cycles want 0", gaps); end
        n_cmp++; if (wr_bursts - w0 !== 1) begin n_err++; $display("FAIL held_write_bursts: got %0d want 1", wr_bursts - w0); end
        n_cmp++; if (resp_pulses - p0 !== 1) begin n_err++; $display("FAIL held_single_access: resp pulses %0d want 1", resp_pulses - p0); end
        n_cmp++; if (rel !== 1'b0) begin n_err++; $display("FAIL held_done_release: got %b want 0", rel); end
        n_cmp++; if (u_sram.mem[14'h0040] !== 8'hBC || u_sram.mem[14'h0041] !== 8'h9A) begin
            n_err++; $display("FAIL held_mem: got %h%h want 9abc", u_sram.mem[14'h0041], u_sram.mem[14'h0040]); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_priority;
        test_wrap;
        test_reset_midop;
        test_held;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
